// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART receiver: register offsets, STATUS bit
// positions and receive FSM state encodings.
// Latency: n/a (definitions only). Backpressure: n/a.
// Ports: none.
package apb_uart_pkg;

  // Register offsets, decoded from PADDR[0]
  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  // STATUS register bit indices
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: synchroniser, edge detect, bit-timing FSM.
// Latency: valid_o pulses in the stop-bit sample cycle (~2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT after the start edge).
// Backpressure: none; downstream must accept every valid_o/frame_err_o pulse.
// Ports: clk_i, rst_i (async, active-high), rx_i (async serial in),
//        data_o (received byte), valid_o (1-cycle good byte), frame_err_o (1-cycle bad stop bit).
module uart_rx_core
  import apb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync2_q, dly_q;
  rx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Edge rather than level: a line held low after a break cannot retrigger.
  assign fall = dly_q & ~sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    valid_o     = 1'b0;
    frame_err_o = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          cnt_d   = HALF_BIT;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            cnt_d   = FULL_BIT;
            bit_d   = '0;
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;  // glitch, not a real start bit
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};  // LSB arrives first
          cnt_d   = FULL_BIT;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          valid_o     = sync2_q;
          frame_err_o = ~sync2_q;
          state_d     = RX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o = shift_q;

endmodule

// File: rtl/apb_uart_rx.sv
// APB UART receiver: uart_rx_core feeding a small byte FIFO, DATA/STATUS registers.
// Latency: byte readable one cycle after the stop-bit sample; APB has zero wait states.
// Backpressure: none on the wire; a push into a full FIFO is dropped and flags overrun.
// Ports: clk, reset (async, active-high), APB slave S_* (only PADDR[0] decoded), rx_wire.
module apb_uart_rx
  import apb_uart_pkg::*;
#(
  parameter int BUS_WIDTH    = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  input  logic                 rx_wire
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_byte;
  logic        rx_vld, rx_ferr;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        empty, full, apb_access, data_sel, pop, push, st_clr;
  logic        unused_bits;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk_i       (clk),
    .rst_i       (reset),
    .rx_i        (rx_wire),
    .data_o      (rx_byte),
    .valid_o     (rx_vld),
    .frame_err_o (rx_ferr)
  );

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign S_PREADY   = S_PSELx & S_PENABLE;
  assign apb_access = S_PSELx & S_PENABLE;
  assign data_sel   = (S_PADDR[0] == UART_REG_DATA);
  assign pop        = apb_access & ~S_PWRITE & data_sel & ~empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push       = rx_vld & (~full | pop);
  assign st_clr     = apb_access & S_PWRITE & (S_PADDR[0] == UART_REG_STATUS);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Set has priority over a W1C in the same cycle.
    overrun_d   = (rx_vld & full & ~pop) | (overrun_q & ~(st_clr & S_PWDATA[ST_OVERRUN]));
    frame_err_d = rx_ferr | (frame_err_q & ~(st_clr & S_PWDATA[ST_FRAME_ERR]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= rx_byte;
  end

  always_comb begin
    S_PRDATA = '0;
    if (S_PSELx) begin
      if (data_sel) begin
        if (!empty) S_PRDATA[7:0] = fifo_mem[rd_ptr_q[AW-1:0]];
      end else begin
        S_PRDATA[ST_NOT_EMPTY] = ~empty;
        S_PRDATA[ST_FULL]      = full;
        S_PRDATA[ST_OVERRUN]   = overrun_q;
        S_PRDATA[ST_FRAME_ERR] = frame_err_q;
      end
    end
  end

  assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[1:0]};

endmodule

// File: tb/tb_apb_uart_rx.sv
module tb_apb_uart_rx;

  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, rx;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] rd;

  always #5 clk = ~clk;

  apb_uart_rx #(.BUS_WIDTH(16), .CLKS_PER_BIT(BIT), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (paddr),
    .S_PWRITE  (pwrite),
    .S_PSELx   (psel),
    .S_PENABLE (penable),
    .S_PWDATA  (pwdata),
    .S_PRDATA  (prdata),
    .S_PREADY  (pready),
    .rx_wire   (rx)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // Drives one 8N1 frame; line is returned high at the end.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT) @(posedge clk); #1 rx = b[i];
    end
    repeat (BIT) @(posedge clk); #1 rx = stop_bit;
    repeat (BIT) @(posedge clk); #1 rx = 1'b1;
  endtask

  task automatic apb_read(input logic addr, output logic [15:0] d);
    @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {15'd0, addr};
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    d = prdata;
    check("pready_rd", {15'd0, pready}, 16'h0001);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_write(input logic addr, input logic [15:0] d);
    @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {15'd0, addr}; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic expect_rd(input string tag, input logic addr, input logic [15:0] exp);
    logic [15:0] d;
    apb_read(addr, d);
    check(tag, d, exp);
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    #1;
    check("rst_prdata", prdata, 16'h0000);
    check("rst_pready", {15'd0, pready}, 16'h0000);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    expect_rd("rst_status", 1'b1, 16'h0000);

    // Plain byte
    send_byte(8'hA5, 1'b1);
    repeat (4) @(posedge clk);
    expect_rd("a5_status", 1'b1, 16'h0001);
    expect_rd("a5_data", 1'b0, 16'h00A5);
    expect_rd("a5_status_after", 1'b1, 16'h0000);

    // Short low glitch: start bit fails mid-bit check
    @(posedge clk); #1 rx = 1'b0;
    repeat (6) @(posedge clk); #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    expect_rd("glitch_status", 1'b1, 16'h0000);

    // Framing error, then W1C
    send_byte(8'h3C, 1'b0);
    repeat (4) @(posedge clk);
    expect_rd("ferr_status", 1'b1, 16'h0008);
    apb_write(1'b1, 16'h0008);
    expect_rd("ferr_cleared", 1'b1, 16'h0000);

    // Break: line held low beyond a frame must not retrigger after the error
    @(posedge clk); #1 rx = 1'b0;
    repeat (250) @(posedge clk); #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    expect_rd("break_status", 1'b1, 16'h0008);
    apb_write(1'b1, 16'h0008);
    expect_rd("break_cleared", 1'b1, 16'h0000);

    // Overrun: five bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    repeat (4) @(posedge clk);
    expect_rd("ovr_status", 1'b1, 16'h0007);
    expect_rd("ovr_rd1", 1'b0, 16'h0001);
    expect_rd("ovr_rd2", 1'b0, 16'h0002);
    expect_rd("ovr_rd3", 1'b0, 16'h0003);
    expect_rd("ovr_rd4", 1'b0, 16'h0004);
    expect_rd("ovr_rd_empty", 1'b0, 16'h0000);
    expect_rd("ovr_sticky", 1'b1, 16'h0004);
    apb_write(1'b1, 16'h0008);
    expect_rd("ovr_wrong_w1c", 1'b1, 16'h0004);
    apb_write(1'b1, 16'h0004);
    expect_rd("ovr_cleared", 1'b1, 16'h0000);

    // Pop coinciding with push while full: stop-bit sample edge is 156 cycles after the start drive edge
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
    repeat (4) @(posedge clk);
    expect_rd("full_status", 1'b1, 16'h0003);
    fork
      send_byte(8'h66, 1'b1);
      begin
        repeat (154) @(posedge clk);
        apb_read(1'b0, rd);
      end
    join
    check("simul_pop", rd, 16'h0011);
    repeat (4) @(posedge clk);
    expect_rd("simul_status", 1'b1, 16'h0003);
    expect_rd("simul_rd2", 1'b0, 16'h0012);
    expect_rd("simul_rd3", 1'b0, 16'h0013);
    expect_rd("simul_rd4", 1'b0, 16'h0014);
    expect_rd("simul_rd5", 1'b0, 16'h0066);
    expect_rd("simul_empty", 1'b1, 16'h0000);

    // Reset mid-frame with a byte already buffered
    send_byte(8'h77, 1'b1);
    repeat (4) @(posedge clk);
    expect_rd("pre_rst_status", 1'b1, 16'h0001);
    @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0001; rx = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1 check("async_clr", prdata, 16'h0000);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; psel = 1'b0;
    repeat (5) @(posedge clk);
    expect_rd("post_rst_status", 1'b1, 16'h0000);
    send_byte(8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b1; paddr = 16'h0000;
    #1;
    check("unsel_pready", {15'd0, pready}, 16'h0000);
    check("unsel_prdata", prdata, 16'h0000);
    penable = 1'b0;
    expect_rd("rst_5a", 1'b0, 16'h005A);
    expect_rd("rst_only_5a", 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
